// File: rtl/morse_timed_decoder.sv
// -----------------------------------------------------------------------------
// morse_timed_decoder
//
// Decodes a raw Morse keying line into ASCII characters. Marks and gaps are
// timed in clock cycles against UNIT_CYCLES (one Morse unit):
//   mark  <  2U      -> dot, otherwise dash
//   gap   <  2U      -> intra-character gap
//   gap  ==  2U      -> character gap: decode and push the character
//   gap  ==  5U      -> word gap: push a space (0x20)
// Decoded bytes are buffered in a show-ahead FIFO with a valid/ready handshake.
//
// Optional feature macro: MORSE_DIGITS_EN
//   defined   : 5-symbol digit codes decode to '0'..'9'
//   undefined : every 5-symbol code decodes to '?' (0x3F) with err
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   key_in      1 = key down (mark), synchronous to clk
//   char_data   ASCII byte at FIFO head, 0x00 when empty
//   char_valid  FIFO non-empty
//   char_ready  consumer accepts head when char_valid & char_ready
//   fifo_count  current FIFO occupancy
//   err         one-cycle pulse when an invalid code is pushed
//   overflow    sticky: a decoded byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module morse_timed_decoder #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_in,
  output logic [7:0]                    char_data,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_GAP  = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_GAP  = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  // A symbol length of 6 flags a character that received too many symbols.
  localparam logic [2:0] LEN_MAX_OK  = 3'd5;
  localparam logic [2:0] LEN_INVALID = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    WGAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       sym_len;
  logic [4:0]       sym_code;

  logic             push_req;
  logic [7:0]       push_data;
  logic             push_bad;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic [8:0]       dec;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // ---------------------------------------------------------------------------
  // Code decode. Symbols enter at bit 0 and move up, so the first symbol of an
  // n-symbol character sits at bit n-1; unused upper code bits stay zero.
  // Returns {invalid, ascii}.
  // ---------------------------------------------------------------------------
  function automatic logic [8:0] decode(input logic [2:0] len, input logic [4:0] code);
    logic [8:0] r;
    r = {1'b1, 8'h3F};
    case ({len, code})
      8'b001_00000: r = {1'b0, 8'h45}; // E .
      8'b001_00001: r = {1'b0, 8'h54}; // T -
      8'b010_00000: r = {1'b0, 8'h49}; // I ..
      8'b010_00001: r = {1'b0, 8'h41}; // A .-
      8'b010_00010: r = {1'b0, 8'h4E}; // N -.
      8'b010_00011: r = {1'b0, 8'h4D}; // M --
      8'b011_00000: r = {1'b0, 8'h53}; // S ...
      8'b011_00001: r = {1'b0, 8'h55}; // U ..-
      8'b011_00010: r = {1'b0, 8'h52}; // R .-.
      8'b011_00011: r = {1'b0, 8'h57}; // W .--
      8'b011_00100: r = {1'b0, 8'h44}; // D -..
      8'b011_00101: r = {1'b0, 8'h4B}; // K -.-
      8'b011_00110: r = {1'b0, 8'h47}; // G --.
      8'b011_00111: r = {1'b0, 8'h4F}; // O ---
      8'b100_00000: r = {1'b0, 8'h48}; // H ....
      8'b100_00001: r = {1'b0, 8'h56}; // V ...-
      8'b100_00010: r = {1'b0, 8'h46}; // F ..-.
      8'b100_00100: r = {1'b0, 8'h4C}; // L .-..
      8'b100_00110: r = {1'b0, 8'h50}; // P .--.
      8'b100_00111: r = {1'b0, 8'h4A}; // J .---
      8'b100_01000: r = {1'b0, 8'h42}; // B -...
      8'b100_01001: r = {1'b0, 8'h58}; // X -..-
      8'b100_01010: r = {1'b0, 8'h43}; // C -.-.
      8'b100_01011: r = {1'b0, 8'h59}; // Y -.--
      8'b100_01100: r = {1'b0, 8'h5A}; // Z --..
      8'b100_01101: r = {1'b0, 8'h51}; // Q --.-
`ifdef MORSE_DIGITS_EN
      8'b101_11111: r = {1'b0, 8'h30}; // 0 -----
      8'b101_01111: r = {1'b0, 8'h31}; // 1 .----
      8'b101_00111: r = {1'b0, 8'h32}; // 2 ..---
      8'b101_00011: r = {1'b0, 8'h33}; // 3 ...--
      8'b101_00001: r = {1'b0, 8'h34}; // 4 ....-
      8'b101_00000: r = {1'b0, 8'h35}; // 5 .....
      8'b101_10000: r = {1'b0, 8'h36}; // 6 -....
      8'b101_11000: r = {1'b0, 8'h37}; // 7 --...
      8'b101_11100: r = {1'b0, 8'h38}; // 8 ---..
      8'b101_11110: r = {1'b0, 8'h39}; // 9 ----.
`endif
      default:      r = {1'b1, 8'h3F};
    endcase
    return r;
  endfunction

  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign dec     = decode(sym_len, sym_code);

  // Push request is combinational so the byte lands in the FIFO on the same
  // edge that samples the final low of the char or word gap.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    push_req  = 1'b0;
    push_data = 8'h00;
    push_bad  = 1'b0;
    if (!key_in) begin
      if (state == GAP && cnt_inc == CHAR_GAP) begin
        push_req  = 1'b1;
        push_data = dec[7:0];
        push_bad  = dec[8];
      end else if (state == WGAP && cnt_inc == WORD_GAP) begin
        push_req  = 1'b1;
        push_data = 8'h20;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timing FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking '<=' so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sym_len  <= '0;
      sym_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_in) begin
            state <= MARK;
            cnt   <= CNT_ONE;
          end
        end

        MARK: begin
          if (key_in) begin
            cnt <= cnt_inc;
          end else begin
            // Classify the finished mark; past five symbols the character is
            // poisoned and later symbols are ignored until the char gap.
            if (sym_len < LEN_MAX_OK) begin
              sym_code <= {sym_code[3:0], (cnt >= DASH_MIN)};
              sym_len  <= sym_len + 3'd1;
            end else begin
              sym_len  <= LEN_INVALID;
            end
            state <= GAP;
            cnt   <= CNT_ONE;
          end
        end

        GAP: begin
          if (key_in) begin
            state <= MARK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CHAR_GAP) begin
              state    <= WGAP;
              sym_len  <= '0;
              sym_code <= '0;
            end
          end
        end

        WGAP: begin
          if (key_in) begin
            state <= MARK;
            cnt   <= CNT_ONE;
          end else if (cnt_inc == WORD_GAP) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  assign char_valid = (fifo_count != '0);
  assign full       = (fifo_count == FIFO_FULL);
  assign pop        = char_valid & char_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req & (~full | pop);
  assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, and char_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      err <= push_req & push_bad;
      if (push_req & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_timed_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_timed_decoder
//
// Self-checking bench for morse_timed_decoder (UNIT_CYCLES=4, FIFO_DEPTH=4).
// A table of Morse codes is keyed with varied mark/gap lengths around the
// dot/dash and gap thresholds; expected bytes go into a scoreboard queue and
// are compared when the DUT presents them. Hand-written sequences cover
// latency, word gaps, FIFO overflow and reset mid-character.
// -----------------------------------------------------------------------------
module tb_morse_timed_decoder;

  localparam int U     = 4;
  localparam int DEPTH = 4;

`ifdef MORSE_DIGITS_EN
  localparam logic [7:0] DIG1 = 8'h31;
  localparam logic [7:0] DIG0 = 8'h30;
  localparam logic       DBAD = 1'b0;
`else
  localparam logic [7:0] DIG1 = 8'h3F;
  localparam logic [7:0] DIG0 = 8'h3F;
  localparam logic       DBAD = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic [2:0] fifo_count;
  logic       err;
  logic       overflow;

  always #5 clk = ~clk;

  morse_timed_decoder #(
    .UNIT_CYCLES (U),
    .CNT_W       (8),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .fifo_count (fifo_count),
    .err        (err),
    .overflow   (overflow)
  );

  typedef struct {
    logic [7:0] ch;
    logic       bad;
  } exp_t;

  typedef struct {
    string      code;
    logic [7:0] ch;
    logic       bad;
    logic       word;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[18];
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare whatever the DUT presents against the scoreboard head.
  task automatic monitor();
    exp_t e;
    if (char_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(char_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_char", 32'(char_data), 32'(e.ch));
        check("sb_err", 32'(err), 32'(e.bad));
      end
    end else begin
      check("err_quiet", 32'(err), 32'd0);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too, after the
  // rising edge that consumed the previous input.
  task automatic step(input logic v);
    key_in = v;
    @(posedge clk);
    @(negedge clk);
    if (mon_en) monitor();
  endtask

  task automatic steps(input logic v, input int n);
    repeat (n) step(v);
  endtask

  // Key one character, alternating short/long marks and gaps around the
  // thresholds, and finish with exactly the 2U-low char gap.
  task automatic send_code(input string code);
    for (int i = 0; i < code.len(); i++) begin
      int m;
      if (code[i] == 8'h2D) m = (i % 2 != 0) ? 2 * U : 3 * U;
      else                  m = (i % 2 != 0) ? 1 : 2 * U - 1;
      steps(1'b1, m);
      if (i != code.len() - 1) steps(1'b0, (i % 2 != 0) ? 1 : 2 * U - 1);
    end
    steps(1'b0, 2 * U);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    key_in     = 1'b0;
    char_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(char_valid), 32'd1);
    check({name, "_data"}, 32'(char_data), 32'(exp));
    char_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{".",      8'h45, 1'b0, 1'b0};
    vecs[1]  = '{"-",      8'h54, 1'b0, 1'b0};
    vecs[2]  = '{".-",     8'h41, 1'b0, 1'b0};
    vecs[3]  = '{"-...",   8'h42, 1'b0, 1'b0};
    vecs[4]  = '{"-.-.",   8'h43, 1'b0, 1'b0};
    vecs[5]  = '{"--..",   8'h5A, 1'b0, 1'b0};
    vecs[6]  = '{"--.-",   8'h51, 1'b0, 1'b1};
    vecs[7]  = '{".---",   8'h4A, 1'b0, 1'b0};
    vecs[8]  = '{"..--",   8'h3F, 1'b1, 1'b0};
    vecs[9]  = '{"----",   8'h3F, 1'b1, 1'b0};
    vecs[10] = '{".-.-",   8'h3F, 1'b1, 1'b0};
    vecs[11] = '{"---.",   8'h3F, 1'b1, 1'b0};
    vecs[12] = '{".----",  DIG1,  DBAD, 1'b0};
    vecs[13] = '{"-----",  DIG0,  DBAD, 1'b1};
    vecs[14] = '{"......", 8'h3F, 1'b1, 1'b0};
    vecs[15] = '{"...",    8'h53, 1'b0, 1'b1};
    vecs[16] = '{"...---", 8'h3F, 1'b1, 1'b0};
    vecs[17] = '{"--",     8'h4D, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_data", 32'(char_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // 'E' latency, then 'A' with no space between, then the word-gap space
    steps(1'b1, 3);
    steps(1'b0, 7);
    check("e_early_valid", 32'(char_valid), 32'd0);
    step(1'b0);
    check("e_valid", 32'(char_valid), 32'd1);
    check("e_data", 32'(char_data), 32'h45);
    check("e_count", 32'(fifo_count), 32'd1);
    check("e_err", 32'(err), 32'd0);
    steps(1'b1, 2);
    steps(1'b0, 2);
    steps(1'b1, 8);
    steps(1'b0, 7);
    check("a_early_count", 32'(fifo_count), 32'd1);
    step(1'b0);
    check("a_count", 32'(fifo_count), 32'd2);
    steps(1'b0, 11);
    check("sp_early_count", 32'(fifo_count), 32'd2);
    step(1'b0);
    check("sp_count", 32'(fifo_count), 32'd3);
    pop_check("rd0", 8'h45);
    pop_check("rd1", 8'h41);
    pop_check("rd2", 8'h20);
    steps(1'b0, 30);
    check("one_space_count", 32'(fifo_count), 32'd0);
    check("empty_data", 32'(char_data), 32'd0);

    // Table of codes through the scoreboard, consumer always ready
    do_reset();
    char_ready = 1'b1;
    mon_en     = 1'b1;
    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].ch, vecs[i].bad});
      if (vecs[i].word) sb.push_back('{8'h20, 1'b0});
      send_code(vecs[i].code);
      if (vecs[i].word) steps(1'b0, 3 * U + 4);
    end
    steps(1'b0, 4);
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Overflow: five 'E's into a 4-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      steps(1'b1, 1);
      steps(1'b0, 2 * U);
    end
    check("ovf_pre_count", 32'(fifo_count), 32'd4);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    steps(1'b1, 1);
    steps(1'b0, 2 * U);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("ovf_rd", 8'h45);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_drained", 32'(fifo_count), 32'd0);

    // Full FIFO with a pop in the push cycle accepts the byte
    do_reset();
    for (int i = 0; i < 4; i++) begin
      steps(1'b1, 1);
      steps(1'b0, 2 * U);
    end
    steps(1'b1, 1);
    steps(1'b0, 2 * U - 1);
    char_ready = 1'b1;
    step(1'b0);
    char_ready = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);

    // Reset during the second mark of 'A'
    do_reset();
    steps(1'b1, 2);
    steps(1'b0, 2);
    steps(1'b1, 4);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(char_valid), 32'd0);
    check("mid_rst_data", 32'(char_data), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    steps(1'b0, 25);
    check("mid_rst_no_byte", 32'(fifo_count), 32'd0);
    steps(1'b1, 3);
    steps(1'b0, 2 * U);
    check("post_rst_valid", 32'(char_valid), 32'd1);
    check("post_rst_data", 32'(char_data), 32'h45);
    check("post_rst_count", 32'(fifo_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
